zion_rsp_skid_buf: RTL and testbench

Two-entry valid/ready register slice (skid buffer) that feeds the enable/clear response DFF stage. It converts an upstream valid/ready stream into a fully registered stream, so neither the data nor the ready path has combinational feed-through. It sustains one transfer per cycle and supports a synchronous flush (`iClr`) that returns the slice to its initial state. Reset and clear load the same `INI_DATA` value into both data registers.

---
 rtl/zion_rsp_skid_buf.sv | 151 +++++++++++++++
 tb/tb_zion_rsp_skid_buf.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/zion_rsp_skid_buf.sv
// ----------------------------------------------------------------------------
// zion_rsp_skid_buf
//
// Two-entry valid/ready register slice (skid buffer) feeding the enable/clear
// response DFF stage. Data, valid and ready are all registered, so there is no
// combinational feed-through in either direction. One beat per cycle is
// sustained while the downstream keeps iRdy high. When the downstream stalls,
// the skid register absorbs the one beat accepted while ready was still high.
//
// Optional feature macro: ZION_SKID_BUF_ERR_CHK_EN
//   When defined, adds the sticky oErr protocol checker. The checker flags
//   upstream valid being dropped, or upstream data changing, while stalled.
//
// Parameters:
//   WIDTH    - data width in bits
//   INI_DATA - value loaded into both data registers on rst / iClr
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   iClr  in   synchronous flush, returns the slice to its reset state
//   iVld  in   upstream valid
//   oRdy  out  upstream ready (registered)
//   iDat  in   upstream data
//   oVld  out  downstream valid (registered)
//   iRdy  in   downstream ready
//   oDat  out  downstream data, driven directly by the main register
//   oErr  out  sticky protocol error (only with ZION_SKID_BUF_ERR_CHK_EN)
// ----------------------------------------------------------------------------
module zion_rsp_skid_buf #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iVld,
    output logic             oRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             iRdy,
    output logic [WIDTH-1:0] oDat
`ifdef ZION_SKID_BUF_ERR_CHK_EN
    ,
    output logic             oErr
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_vld;
    logic             r_rdy;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_up;
    logic w_dn;
    logic w_flush;

    assign w_up    = iVld & r_rdy;
    assign w_dn    = r_vld & iRdy;
    assign w_flush = rst | iClr;

    // NOTE: reset is synchronous here, so it is only sampled inside the
    // clocked block and never appears in the sensitivity list.
    // NOTE: state is updated with non-blocking assignments only, so every
    // register sees the pre-edge values of its neighbours (main <= skid).
    always_ff @(posedge clk) begin
        if (w_flush) begin
            // NOTE: the data registers are deliberately reset; oDat must
            // show INI_DATA after reset or flush, not stale content.
            r_state <= ST_EMPTY;
            r_vld   <= 1'b0;
            r_rdy   <= 1'b1;
            r_main  <= INI_DATA;
            r_skid  <= INI_DATA;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_up) begin
                        r_main  <= iDat;
                        r_state <= ST_BUSY;
                        r_vld   <= 1'b1;
                        r_rdy   <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_up && w_dn) begin
                        r_main <= iDat;
                    end else if (w_up) begin
                        // Downstream stalled on the same edge we accepted:
                        // park the new beat in the skid register.
                        r_skid  <= iDat;
                        r_state <= ST_FULL;
                        r_rdy   <= 1'b0;
                    end else if (w_dn) begin
                        r_state <= ST_EMPTY;
                        r_vld   <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // No upstream accept is possible here since oRdy is low.
                    if (w_dn) begin
                        r_main  <= r_skid;
                        r_state <= ST_BUSY;
                        r_rdy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_vld   <= 1'b0;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign oVld = r_vld;
    assign oRdy = r_rdy;
    assign oDat = r_main;

`ifdef ZION_SKID_BUF_ERR_CHK_EN
    // A stall is a cycle with iVld high while oRdy is low. The upstream must
    // then hold iVld and iDat unchanged into the following cycle.
    logic             r_stall;
    logic [WIDTH-1:0] r_stall_dat;
    logic             r_err;

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_stall     <= 1'b0;
            r_stall_dat <= INI_DATA;
            r_err       <= 1'b0;
        end else begin
            r_stall     <= iVld & ~r_rdy;
            r_stall_dat <= iDat;
            if (r_stall && (!iVld || (iDat != r_stall_dat))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign oErr = r_err;
`endif

endmodule

// File: tb/tb_zion_rsp_skid_buf.sv
// ----------------------------------------------------------------------------
// tb_zion_rsp_skid_buf
//
// Self-checking bench for zion_rsp_skid_buf. The reference model is a queue
// of at most two beats. oVld means "queue not empty" and oRdy means "queue
// not full". oDat is the head of the queue, or the last head when the queue
// is empty. Directed sequences are followed by a randomized run.
// Compile with +define+ZION_SKID_BUF_ERR_CHK_EN to also check oErr.
// ----------------------------------------------------------------------------
module tb_zion_rsp_skid_buf;

    localparam int         W   = 8;
    localparam logic [7:0] INI = 8'h5A;

    logic         clk = 1'b0;
    logic         rst;
    logic         iClr;
    logic         iVld;
    logic         oRdy;
    logic [W-1:0] iDat;
    logic         oVld;
    logic         iRdy;
    logic [W-1:0] oDat;
`ifdef ZION_SKID_BUF_ERR_CHK_EN
    logic         oErr;
`endif

    zion_rsp_skid_buf #(
        .WIDTH   (W),
        .INI_DATA(INI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .iClr(iClr),
        .iVld(iVld),
        .oRdy(oRdy),
        .iDat(iDat),
        .oVld(oVld),
        .iRdy(iRdy),
        .oDat(oDat)
`ifdef ZION_SKID_BUF_ERR_CHK_EN
        ,
        .oErr(oErr)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_dat   = INI;
    logic         m_err   = 1'b0;
    logic         m_stall = 1'b0;
    logic [W-1:0] m_sdat  = INI;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        int  sz;
        bit  up;
        bit  dn;
        bit  err_hit;
        sz      = m_q.size();
        up      = iVld && (sz < 2);
        dn      = (sz > 0) && iRdy;
        err_hit = m_stall && (!iVld || (iDat != m_sdat));
        if (rst || iClr) begin
            m_q.delete();
            m_dat   = INI;
            m_err   = 1'b0;
            m_stall = 1'b0;
            m_sdat  = INI;
        end else begin
            if (dn) void'(m_q.pop_front());
            if (up) m_q.push_back(iDat);
            if (m_q.size() > 0) m_dat = m_q[0];
            if (err_hit) m_err = 1'b1;
            m_stall = iVld && (sz >= 2);
            m_sdat  = iDat;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_vld"}, 32'(oVld), 32'(m_q.size() > 0));
        check({tag, "_rdy"}, 32'(oRdy), 32'(m_q.size() < 2));
        check({tag, "_dat"}, 32'(oDat), 32'(m_dat));
`ifdef ZION_SKID_BUF_ERR_CHK_EN
        check({tag, "_err"}, 32'(oErr), 32'(m_err));
`endif
    endtask

    // One clock: the model steps on the same edge as the DUT, and outputs
    // are sampled 1 time unit later, well away from the next edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
        iVld = v;
        iDat = d;
        iRdy = r;
    endtask

    initial begin
        rst  = 1'b1;
        iClr = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        tick("rst");
        tick("rst2");
        rst = 1'b0;

        // Idle after reset
        tick("idle");
        check("idle_vld", 32'(oVld), 32'd0);
        check("idle_rdy", 32'(oRdy), 32'd1);
        check("idle_dat", 32'(oDat), 32'(INI));

        // Single beat, 1-cycle latency
        drive(1'b1, 8'h11, 1'b0);
        tick("one");
        check("one_dat", 32'(oDat), 32'h11);
        check("one_vld", 32'(oVld), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        tick("one_drain");
        tick("one_hold");
        check("hold_dat", 32'(oDat), 32'h11);

        // Back-to-back stream, iRdy high
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 8'(k), 1'b1);
            tick("strm");
            check("strm_dat", 32'(oDat), 32'(k));
            check("strm_rdy", 32'(oRdy), 32'd1);
        end
        drive(1'b0, 8'h00, 1'b1);
        tick("strm_end");

        // Downstream stall: A1 in main, A2 in skid, A3 held upstream
        drive(1'b1, 8'hA1, 1'b0);
        tick("stl1");
        drive(1'b1, 8'hA2, 1'b0);
        tick("stl2");
        check("full_rdy", 32'(oRdy), 32'd0);
        check("full_dat", 32'(oDat), 32'hA1);
        drive(1'b1, 8'hA3, 1'b0);
        tick("stl3");
        check("held_dat", 32'(oDat), 32'hA1);
        drive(1'b1, 8'hA3, 1'b1);
        tick("rel1");
        check("rel_a2", 32'(oDat), 32'hA2);
        tick("rel2");
        check("rel_a3", 32'(oDat), 32'hA3);
        drive(1'b0, 8'h00, 1'b1);
        tick("rel3");
        check("rel_empty", 32'(oVld), 32'd0);

        // Flush while FULL with a concurrent upstream beat
        drive(1'b1, 8'hB1, 1'b0);
        tick("b1");
        drive(1'b1, 8'hB2, 1'b0);
        tick("b2");
        iClr = 1'b1;
        drive(1'b1, 8'hB3, 1'b0);
        tick("clr");
        check("clr_vld", 32'(oVld), 32'd0);
        check("clr_rdy", 32'(oRdy), 32'd1);
        check("clr_dat", 32'(oDat), 32'(INI));
        iClr = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        tick("clr_post");
        check("no_b2", 32'(oVld), 32'd0);

        // Reset while BUSY
        drive(1'b1, 8'hC1, 1'b0);
        tick("c1");
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick("rst_busy");
        check("rstb_dat", 32'(oDat), 32'(INI));
        rst = 1'b0;
        drive(1'b1, 8'hC2, 1'b0);
        tick("c2");
        check("c2_dat", 32'(oDat), 32'hC2);
        drive(1'b0, 8'h00, 1'b1);
        tick("c2_drain");

        // Data changed while stalled
        drive(1'b1, 8'hD0, 1'b0);
        tick("d0a");
        tick("d0b");
        tick("d0c");
        drive(1'b1, 8'hD1, 1'b0);
        tick("d1");
`ifdef ZION_SKID_BUF_ERR_CHK_EN
        check("err_set", 32'(oErr), 32'd1);
`endif
        drive(1'b0, 8'h00, 1'b1);
        tick("d_drain1");
        tick("d_drain2");
`ifdef ZION_SKID_BUF_ERR_CHK_EN
        check("err_sticky", 32'(oErr), 32'd1);
`endif
        iClr = 1'b1;
        tick("err_clr");
        iClr = 1'b0;
`ifdef ZION_SKID_BUF_ERR_CHK_EN
        check("err_clr", 32'(oErr), 32'd0);
`endif

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            iClr = ($urandom_range(0, 39) == 0);
            drive(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 6));
            tick("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
